// File: rtl/fetch_responder.sv
// Fetch-port responder backed by a LINES-entry direct-mapped, single-word
// instruction cache that refills from a backing memory on a miss.
module fetch_responder #(
    parameter int unsigned LINES  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_data,
    output logic              fetch_ready,
    input  logic              inv,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t              state;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [ADDR_W-1:0]   word_addr_c;
    logic [IDX_W-1:0]    req_idx_c;
    logic [TAG_W-1:0]    req_tag_c;
    logic [IDX_W-1:0]    fill_idx_c;
    logic [TAG_W-1:0]    fill_tag_c;
    logic                hit_c;
    logic                fill_c;

    // Lookup uses the live request; the fill uses the address captured at miss time.
    assign word_addr_c = fetch_addr & ~ADDR_W'(3);
    assign req_idx_c   = word_addr_c[IDX_W+1:2];
    assign req_tag_c   = word_addr_c[ADDR_W-1:IDX_W+2];
    assign fill_idx_c  = mem_addr[IDX_W+1:2];
    assign fill_tag_c  = mem_addr[ADDR_W-1:IDX_W+2];
    assign hit_c       = valid[req_idx_c] && (tag_mem[req_idx_c] == req_tag_c);
    assign fill_c      = (state == MISS) && mem_ack;

    // Tag and data storage carry no reset; validity alone qualifies an entry.
    always_ff @(posedge clk) begin
        if (fill_c) begin
            tag_mem[fill_idx_c]  <= fill_tag_c;
            data_mem[fill_idx_c] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            valid       <= '0;
            fetch_ready <= 1'b0;
            fetch_data  <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else begin
            fetch_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        if (hit_c) begin
                            fetch_data  <= data_mem[req_idx_c];
                            fetch_ready <= 1'b1;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= word_addr_c;
                            state    <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (mem_ack) begin
                        fetch_data         <= mem_rdata;
                        fetch_ready        <= 1'b1;
                        mem_req            <= 1'b0;
                        valid[fill_idx_c]  <= 1'b1;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Invalidate is last so it overrides a coincident fill.
            if (inv) begin
                valid <= '0;
            end
        end
    end

endmodule
